// File: rtl/arbitro_memoria.sv
// arbitro_memoria
//   Shares one single-port memory between the CPU control unit (AR/DR traffic)
//   and the boot-time program loader (Cargador). Each requester uses a Req/Ack
//   handshake; the arbiter sequences the memory strobes for ESPERAS+1 access
//   cycles, then pulses the winner's Ack for exactly one cycle.
//
//   State sequence: REPOSO -> ACCESO -> FIN -> REPOSO.
//   Latency: Req sampled at the edge ending cycle t -> Ack high in cycle
//   t+ESPERAS+2. Minimum repeat period is ESPERAS+3 cycles.
//
//   Build option: define ARB_PRIORIDAD_CPU_EN for fixed CPU priority on ties.
//   Left undefined, ties alternate round-robin and the CPU wins the first tie
//   after reset.
module arbitro_memoria #(
   parameter int ANCHO_DIR  = 16,
   parameter int ANCHO_DATO = 16,
   parameter int ESPERAS    = 2
) (
   input  logic                  Reloj,
   input  logic                  Reiniciar,
   // CPU requester
   input  logic                  CpuReq,
   input  logic                  CpuEscribe,
   input  logic [ANCHO_DIR-1:0]  CpuDir,
   input  logic [ANCHO_DATO-1:0] CpuDato,
   output logic                  CpuAck,
   // Loader requester
   input  logic                  CarReq,
   input  logic                  CarEscribe,
   input  logic [ANCHO_DIR-1:0]  CarDir,
   input  logic [ANCHO_DATO-1:0] CarDato,
   output logic                  CarAck,
   // Read data returned to whichever requester issued the last read
   output logic [ANCHO_DATO-1:0] DatoLeido,
   // Memory side
   output logic [ANCHO_DIR-1:0]  MemDir,
   output logic [ANCHO_DATO-1:0] MemDatoEsc,
   output logic                  MemSel,
   output logic                  MemEsc,
   input  logic [ANCHO_DATO-1:0] MemDatoLec
);

   typedef enum logic [1:0] {
      REPOSO = 2'd0,
      ACCESO = 2'd1,
      FIN    = 2'd2
   } estado_t;

   // Wait-state count loaded at grant; the counter is 4 bits wide (0..15).
   localparam logic [3:0] C_ESPERAS = 4'(ESPERAS);

   estado_t               r_estado;
   logic [3:0]            r_cuenta;
   logic                  r_ganador_car;   // 1: current transaction belongs to the loader
   logic                  r_cpu_ack;
   logic                  r_car_ack;
   logic                  r_mem_sel;
   logic                  r_mem_esc;
   logic [ANCHO_DIR-1:0]  r_mem_dir;
   logic [ANCHO_DATO-1:0] r_mem_dato_esc;
   logic [ANCHO_DATO-1:0] r_dato_leido;
`ifndef ARB_PRIORIDAD_CPU_EN
   logic                  r_ultimo_car;    // 1: last grant went to the loader
`endif

   logic                  w_hay_req;
   logic                  w_gana_car;
   logic                  w_esc_sel;
   logic [ANCHO_DIR-1:0]  w_dir_sel;
   logic [ANCHO_DATO-1:0] w_dato_sel;

   // Pick the winner for a grant in REPOSO and mux its access attributes.
   always_comb begin
      // NOTE: every signal gets a default before any condition, so no path
      // leaves it unassigned and no latch is inferred.
      w_hay_req  = CpuReq | CarReq;
      w_gana_car = 1'b0;
`ifdef ARB_PRIORIDAD_CPU_EN
      // Loader only wins when the CPU is not asking at all.
      w_gana_car = CarReq & ~CpuReq;
`else
      // Loader wins alone, or on a tie when the CPU had the previous grant.
      w_gana_car = CarReq & (~CpuReq | ~r_ultimo_car);
`endif
      w_esc_sel  = CpuEscribe;
      w_dir_sel  = CpuDir;
      w_dato_sel = CpuDato;
      if (w_gana_car) begin
         w_esc_sel  = CarEscribe;
         w_dir_sel  = CarDir;
         w_dato_sel = CarDato;
      end
   end

   // Arbitration FSM with registered memory strobes, Acks and read data.
   always_ff @(posedge Reloj) begin
      // NOTE: state and outputs use non-blocking assignments so every register
      // sees the pre-edge values of the others, matching real flip-flops.
      if (Reiniciar) begin
         r_estado       <= REPOSO;
         r_cuenta       <= 4'd0;
         r_ganador_car  <= 1'b0;
         r_cpu_ack      <= 1'b0;
         r_car_ack      <= 1'b0;
         r_mem_sel      <= 1'b0;
         r_mem_esc      <= 1'b0;
         r_mem_dir      <= '0;
         r_mem_dato_esc <= '0;
         r_dato_leido   <= '0;
`ifndef ARB_PRIORIDAD_CPU_EN
         r_ultimo_car   <= 1'b1;
`endif
      end else begin
         case (r_estado)
            REPOSO: begin
               r_cpu_ack <= 1'b0;
               r_car_ack <= 1'b0;
               if (w_hay_req) begin
                  // Grant edge: capture the winner's request for the whole access.
                  r_ganador_car  <= w_gana_car;
                  r_mem_esc      <= w_esc_sel;
                  r_mem_dir      <= w_dir_sel;
                  r_mem_dato_esc <= w_dato_sel;
                  r_mem_sel      <= 1'b1;
                  r_cuenta       <= C_ESPERAS;
`ifndef ARB_PRIORIDAD_CPU_EN
                  r_ultimo_car   <= w_gana_car;
`endif
                  r_estado       <= ACCESO;
               end
            end

            ACCESO: begin
               // Address, data and strobes stay frozen while the memory works.
               if (r_cuenta != 4'd0) begin
                  r_cuenta <= r_cuenta - 4'd1;
               end else begin
                  // Last access cycle: read data is valid now.
                  if (!r_mem_esc) begin
                     r_dato_leido <= MemDatoLec;
                  end
                  r_mem_sel <= 1'b0;
                  r_mem_esc <= 1'b0;
                  r_cpu_ack <= ~r_ganador_car;
                  r_car_ack <= r_ganador_car;
                  r_estado  <= FIN;
               end
            end

            FIN: begin
               // Ack is visible for this one cycle; Req seen here is ignored.
               r_cpu_ack <= 1'b0;
               r_car_ack <= 1'b0;
               r_estado  <= REPOSO;
            end

            default: begin
               r_cpu_ack <= 1'b0;
               r_car_ack <= 1'b0;
               r_mem_sel <= 1'b0;
               r_mem_esc <= 1'b0;
               r_estado  <= REPOSO;
            end
         endcase
      end
   end

   assign CpuAck     = r_cpu_ack;
   assign CarAck     = r_car_ack;
   assign DatoLeido  = r_dato_leido;
   assign MemDir     = r_mem_dir;
   assign MemDatoEsc = r_mem_dato_esc;
   assign MemSel     = r_mem_sel;
   assign MemEsc     = r_mem_esc;

endmodule

// File: tb/tb_arbitro_memoria.sv
// tb_arbitro_memoria
//   Two arbiter instances: index 0 with ESPERAS=2, index 1 with ESPERAS=0.
//   Stimulus pushes the expected completion of each request into a per-instance
//   queue; the monitor compares the memory strobes while MemSel is high and
//   pops one entry per Ack. A small memory model serves reads and stores writes.
module tb_arbitro_memoria;

   typedef struct {
      bit          car;       // 1: loader completion expected
      int          ciclo;     // cycle in which Ack must be high
      bit          esc;
      logic [15:0] dir;
      logic [15:0] dato_esc;
      logic [15:0] leido;     // DatoLeido expected in the Ack cycle
   } exp_t;

   logic        clk = 1'b0;
   logic        rst          [2];
   logic        cpu_req      [2];
   logic        cpu_esc      [2];
   logic [15:0] cpu_dir      [2];
   logic [15:0] cpu_dato     [2];
   logic        cpu_ack      [2];
   logic        car_req      [2];
   logic        car_esc      [2];
   logic [15:0] car_dir      [2];
   logic [15:0] car_dato     [2];
   logic        car_ack      [2];
   logic [15:0] dato_leido   [2];
   logic [15:0] mem_dir      [2];
   logic [15:0] mem_dato_esc [2];
   logic        mem_sel      [2];
   logic        mem_esc      [2];
   logic [15:0] mem_lec      [2];

   logic [15:0] mem [2][256];
   bit          val [2][256];

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t sb_q [2][$];
   int   sel_count [2] = '{0, 0};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int esperas(input int g);
      return (g == 0) ? 2 : 0;
   endfunction

   // Power-on memory contents for the locations the tests read.
   function automatic logic [15:0] contenido_inicial(input logic [15:0] a);
      case (a)
         16'h0010: return 16'hBEEF;
         16'h0020: return 16'hCAFE;
         16'h0030: return 16'h1111;
         16'h0040: return 16'hA0A0;
         16'h0041: return 16'h5B5B;
         16'h0042: return 16'hC3C3;
         16'h0043: return 16'h0F0F;
         default:  return 16'h0000;
      endcase
   endfunction

   task automatic check(input string nombre, input logic [31:0] actual, input logic [31:0] esperado);
      checks++;
      if (actual !== esperado) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nombre, actual, esperado, cyc);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_dut
      arbitro_memoria #(
         .ANCHO_DIR (16),
         .ANCHO_DATO(16),
         .ESPERAS   ((g == 0) ? 2 : 0)
      ) u_dut (
         .Reloj     (clk),
         .Reiniciar (rst[g]),
         .CpuReq    (cpu_req[g]),
         .CpuEscribe(cpu_esc[g]),
         .CpuDir    (cpu_dir[g]),
         .CpuDato   (cpu_dato[g]),
         .CpuAck    (cpu_ack[g]),
         .CarReq    (car_req[g]),
         .CarEscribe(car_esc[g]),
         .CarDir    (car_dir[g]),
         .CarDato   (car_dato[g]),
         .CarAck    (car_ack[g]),
         .DatoLeido (dato_leido[g]),
         .MemDir    (mem_dir[g]),
         .MemDatoEsc(mem_dato_esc[g]),
         .MemSel    (mem_sel[g]),
         .MemEsc    (mem_esc[g]),
         .MemDatoLec(mem_lec[g])
      );
   end

   // Memory model: combinational read, write on every selected write cycle.
   always_comb begin
      for (int g = 0; g < 2; g++) begin
         mem_lec[g] = val[g][mem_dir[g][7:0]] ? mem[g][mem_dir[g][7:0]]
                                              : contenido_inicial(mem_dir[g]);
      end
   end

   always @(posedge clk) begin
      for (int g = 0; g < 2; g++) begin
         if (mem_sel[g] === 1'b1 && mem_esc[g] === 1'b1) begin
            mem[g][mem_dir[g][7:0]] <= mem_dato_esc[g];
            val[g][mem_dir[g][7:0]] <= 1'b1;
         end
      end
   end

   // Monitor: strobe stability during access, then one scoreboard pop per Ack.
   always @(negedge clk) begin
      exp_t e;
      for (int g = 0; g < 2; g++) begin
         if (mem_sel[g] === 1'b1) begin
            sel_count[g]++;
            check($sformatf("sel_con_transaccion[%0d]", g), 32'(sb_q[g].size() > 0), 1);
            if (sb_q[g].size() > 0) begin
               e = sb_q[g][0];
               check($sformatf("mem_dir[%0d]", g), mem_dir[g], e.dir);
               check($sformatf("mem_esc[%0d]", g), mem_esc[g], e.esc);
               if (e.esc) check($sformatf("mem_dato_esc[%0d]", g), mem_dato_esc[g], e.dato_esc);
            end
         end
         if (rst[g]) sel_count[g] = 0;
         if (cpu_ack[g] === 1'b1 || car_ack[g] === 1'b1) begin
            if (sb_q[g].size() == 0) begin
               check($sformatf("ack_inesperado[%0d]", g), sb_q[g].size(), 1);
            end else begin
               e = sb_q[g].pop_front();
               check($sformatf("ack_quien[%0d]", g), {cpu_ack[g], car_ack[g]}, e.car ? 2'b01 : 2'b10);
               check($sformatf("ack_ciclo[%0d]", g), cyc, e.ciclo);
               check($sformatf("ciclos_sel[%0d]", g), sel_count[g], esperas(g) + 1);
               check($sformatf("sel_en_ack[%0d]", g), mem_sel[g], 0);
               check($sformatf("dato_leido[%0d]", g), dato_leido[g], e.leido);
            end
            sel_count[g] = 0;
         end
      end
   end

   task automatic pedir(input int g, input bit car, input bit esc, input logic [15:0] dir,
                        input logic [15:0] dato);
      if (car) begin
         car_esc[g] = esc; car_dir[g] = dir; car_dato[g] = dato; car_req[g] = 1'b1;
      end else begin
         cpu_esc[g] = esc; cpu_dir[g] = dir; cpu_dato[g] = dato; cpu_req[g] = 1'b1;
      end
   endtask

   task automatic esperar(input int g, input bit car, input int ciclo, input bit esc,
                          input logic [15:0] dir, input logic [15:0] dato, input logic [15:0] leido);
      exp_t e;
      e.car = car; e.ciclo = ciclo; e.esc = esc; e.dir = dir; e.dato_esc = dato; e.leido = leido;
      sb_q[g].push_back(e);
   endtask

   // Bounded wait for the requester's Ack; optionally garbles the non-Req
   // inputs right after the grant edge. Returns at #1 after the edge ending
   // the Ack cycle, where the caller drops or renews the request.
   task automatic esperar_ack(input int g, input bit car, input bit desordenar);
      bit visto = 1'b0;
      if (desordenar) begin
         @(posedge clk); #1;
         if (car) begin
            car_dir[g] = 16'hDEAD; car_dato[g] = 16'hDEAD; car_esc[g] = ~car_esc[g];
         end else begin
            cpu_dir[g] = 16'hDEAD; cpu_dato[g] = 16'hDEAD; cpu_esc[g] = ~cpu_esc[g];
         end
      end
      for (int k = 0; k < 40 && !visto; k++) begin
         @(negedge clk);
         visto = car ? car_ack[g] : cpu_ack[g];
      end
      check($sformatf("ack_a_tiempo[%0d]", g), visto, 1);
      @(posedge clk); #1;
   endtask

   task automatic revisar_reposo(input int g, input string etapa);
      check($sformatf("%s_sel[%0d]", etapa, g), mem_sel[g], 0);
      check($sformatf("%s_esc[%0d]", etapa, g), mem_esc[g], 0);
      check($sformatf("%s_acks[%0d]", etapa, g), {cpu_ack[g], car_ack[g]}, 0);
      check($sformatf("%s_leido[%0d]", etapa, g), dato_leido[g], 0);
      check($sformatf("%s_dir[%0d]", etapa, g), mem_dir[g], 0);
      check($sformatf("%s_dato_esc[%0d]", etapa, g), mem_dato_esc[g], 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int n_cpu;
      int n_car;
      for (int g = 0; g < 2; g++) begin
         rst[g] = 1'b1;
         cpu_req[g] = 1'b0; cpu_esc[g] = 1'b0; cpu_dir[g] = '0; cpu_dato[g] = '0;
         car_req[g] = 1'b0; car_esc[g] = 1'b0; car_dir[g] = '0; car_dato[g] = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      revisar_reposo(0, "reset");
      revisar_reposo(1, "reset");
      rst[0] = 1'b0;
      rst[1] = 1'b0;
      @(posedge clk); #1;

      // CPU read 0x0010 -> 0xBEEF, Ack in cycle 4.
      base = cyc;
      esperar(0, 1'b0, base + 4, 1'b0, 16'h0010, 16'h0000, 16'hBEEF);
      pedir(0, 1'b0, 1'b0, 16'h0010, 16'h0000);
      esperar_ack(0, 1'b0, 1'b1);
      cpu_req[0] = 1'b0;
      @(posedge clk); #1;

      // Loader write 0x0005 <= 0x1234; DatoLeido keeps 0xBEEF.
      base = cyc;
      esperar(0, 1'b1, base + 4, 1'b1, 16'h0005, 16'h1234, 16'hBEEF);
      pedir(0, 1'b1, 1'b1, 16'h0005, 16'h1234);
      esperar_ack(0, 1'b1, 1'b1);
      car_req[0] = 1'b0;
      @(posedge clk); #1;

      // CPU reads back the loaded word.
      base = cyc;
      esperar(0, 1'b0, base + 4, 1'b0, 16'h0005, 16'h0000, 16'h1234);
      pedir(0, 1'b0, 1'b0, 16'h0005, 16'h0000);
      esperar_ack(0, 1'b0, 1'b1);
      cpu_req[0] = 1'b0;

      // Both requesting from reset: CPU reads 0x0020, loader reads 0x0030.
      rst[0] = 1'b1;
      @(posedge clk); #1;
      rst[0] = 1'b0;
      base = cyc;
`ifdef ARB_PRIORIDAD_CPU_EN
      esperar(0, 1'b0, base + 4,  1'b0, 16'h0020, 16'h0000, 16'hCAFE);
      esperar(0, 1'b0, base + 9,  1'b0, 16'h0020, 16'h0000, 16'hCAFE);
      esperar(0, 1'b1, base + 14, 1'b0, 16'h0030, 16'h0000, 16'h1111);
      esperar(0, 1'b1, base + 19, 1'b0, 16'h0030, 16'h0000, 16'h1111);
`else
      esperar(0, 1'b0, base + 4,  1'b0, 16'h0020, 16'h0000, 16'hCAFE);
      esperar(0, 1'b1, base + 9,  1'b0, 16'h0030, 16'h0000, 16'h1111);
      esperar(0, 1'b0, base + 14, 1'b0, 16'h0020, 16'h0000, 16'hCAFE);
      esperar(0, 1'b1, base + 19, 1'b0, 16'h0030, 16'h0000, 16'h1111);
`endif
      pedir(0, 1'b0, 1'b0, 16'h0020, 16'h0000);
      pedir(0, 1'b1, 1'b0, 16'h0030, 16'h0000);
      n_cpu = 0;
      n_car = 0;
      for (int k = 0; k < 60 && (n_cpu < 2 || n_car < 2); k++) begin
         @(negedge clk);
         if (cpu_ack[0]) n_cpu++;
         if (car_ack[0]) n_car++;
         @(posedge clk); #1;
         if (n_cpu >= 2) cpu_req[0] = 1'b0;
         if (n_car >= 2) car_req[0] = 1'b0;
      end
      check("empate_acks", n_cpu + n_car, 4);
      @(posedge clk); #1;

      // Reset in cycle 2 of a CPU read; Req stays high -> retried, Ack in cycle 7.
      base = cyc;
      esperar(0, 1'b0, base + 7, 1'b0, 16'h0010, 16'h0000, 16'hBEEF);
      pedir(0, 1'b0, 1'b0, 16'h0010, 16'h0000);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst[0] = 1'b1;
      @(posedge clk); #1;
      rst[0] = 1'b0;
      revisar_reposo(0, "aborto");
      esperar_ack(0, 1'b0, 1'b1);
      cpu_req[0] = 1'b0;

      // ESPERAS=0: back-to-back CPU reads every 3 cycles.
      @(posedge clk); #1;
      base = cyc;
      for (int i = 0; i < 4; i++) begin
         esperar(1, 1'b0, base + 2 + 3 * i, 1'b0, 16'h0040 + 16'(i), 16'h0000,
                 contenido_inicial(16'h0040 + 16'(i)));
      end
      pedir(1, 1'b0, 1'b0, 16'h0040, 16'h0000);
      for (int i = 0; i < 4; i++) begin
         esperar_ack(1, 1'b0, 1'b0);
         if (i < 3) cpu_dir[1] = 16'h0041 + 16'(i);
         else       cpu_req[1] = 1'b0;
      end

      for (int k = 0; k < 50 && (sb_q[0].size() + sb_q[1].size()) > 0; k++) @(negedge clk);
      check("cola_vacia", sb_q[0].size() + sb_q[1].size(), 0);
      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
